mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Parametrised memory-port controller: arbitrates NCH pipeline requesters (e.g. fetch, load/store)
//  onto one req/rdy/valid memory port. Generates per-channel stall, returns read data, flags timeouts.
//  Sits between the datapath/CU and a shared memory; replaces per-memory fixed handshake glue.
// PARAMETERS
//  NBITS        32  address/data width
//  NCH          2   number of requesting channels (>=1); channel 0 = highest fixed priority
//  TIMEOUT_CYC  64  max cycles in WAIT before abort; 0 disables timeout
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          asynchronous, active-low reset
//  ch_req     in   NCH        channel i requests; held high until its ch_valid
//  ch_we      in   NCH        1 = write, 0 = read
//  ch_addr    in   NCH*NBITS  channel i address, slice [i*NBITS +: NBITS]
//  ch_wdata   in   NCH*NBITS  channel i write data
//  ch_valid   out  NCH        1-cycle completion pulse to channel i
//  ch_err     out  NCH        1-cycle timeout pulse, coincident with ch_valid
//  ch_rdata   out  NBITS      read data, meaningful while any ch_valid high
//  ch_stall   out  NCH        channel i must freeze its pipeline
//  busy       out  1          FSM not IDLE
//  mem_req    out  1          memory request
//  mem_rdy    in   1          memory accepts request (handshake = mem_req & mem_rdy)
//  mem_we     out  1          latched write enable
//  mem_addr   out  NBITS      latched address
//  mem_wdata  out  NBITS      latched write data
//  mem_valid  in   1          memory response/completion
//  mem_rdata  in   NBITS      memory read data
// BEHAVIOUR
//  - Reset (rst=0, async): FSM=IDLE; all outputs 0; timeout counter 0; RR pointer 0.
//  - FSM IDLE: if |ch_req, pick winner, latch id/we/addr/wdata into regs -> REQ. Else stay.
//  - REQ: mem_req=1, mem_addr/we/wdata stable from latched regs. On mem_req&mem_rdy -> WAIT,
//    mem_req drops next cycle. mem_rdy low: hold indefinitely (no timeout in REQ).
//  - WAIT: mem_req=0; counter increments each cycle. On mem_valid: ch_valid[id]=1 next cycle,
//    ch_rdata=mem_rdata registered (0 for writes), -> IDLE. If TIMEOUT_CYC!=0 and counter reaches
//    TIMEOUT_CYC with no mem_valid: ch_valid[id]=1, ch_err[id]=1, ch_rdata=0, -> IDLE.
//  - mem_valid in IDLE/REQ ignored. mem_valid and timeout same cycle: mem_valid wins, no err.
//  - Min latency: ch_req sampled edge N -> mem_req high N+1 -> (rdy) WAIT N+2 -> mem_valid N+2
//    -> ch_valid N+3. IDLE returns for >=1 cycle between transactions.
//  - ch_valid/ch_err registered, single-cycle, one-hot or zero; ch_rdata holds last value otherwise.
//  - ch_stall[i] = ch_req[i] & ~ch_valid[i] (combinational); stall drops in completion cycle.
//  - Dropping ch_req[i] before completion is illegal; transaction still completes, pulse still sent.
//  - Counter width $clog2(TIMEOUT_CYC+1), saturating; cleared on leaving WAIT.
//  - Reset mid-transaction aborts: no ch_valid issued, mem_req drops immediately.
// CONFIGURATION
//  ARB_RR_EN defined: round-robin; search starts at channel after last winner, pointer updates
//    on IDLE->REQ, wraps NCH-1 -> 0.
//  ARB_RR_EN undefined: fixed priority, lowest index wins; starvation of high indices permitted.
// TESTING
//  1 NCH=2, ch0 read 0x100, mem_rdy=1, mem_valid 1 cycle after accept, mem_rdata=0xDEADBEEF
//    -> mem_addr=0x100, ch_valid[0] at N+3, ch_rdata=0xDEADBEEF, ch_stall[0] high N..N+2.
//  2 ch0 and ch1 request same cycle, ch1 write 0x200 data 0x55 -> fixed: ch0 served first then ch1;
//    ARB_RR_EN with both held: grants alternate 0,1,0,1 over 4 transactions.
//  3 mem_rdy low 10 cycles in REQ -> mem_req/mem_addr stable 10 cycles, no ch_err.
//  4 TIMEOUT_CYC=4, no mem_valid -> ch_valid[id]=ch_err[id]=1 after 4 WAIT cycles, ch_rdata=0, IDLE.
//  5 rst low during WAIT -> mem_req=0, ch_valid=0, busy=0 immediately; post-reset fresh request ok.
//  6 mem_valid pulsed while IDLE -> no ch_valid, state unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - NCH-channel memory-port arbiter with req/rdy/valid port, stall and timeout (ARB_RR_EN selects round-robin)
module mem_port_arbiter #(
    parameter int NBITS       = 32,
    parameter int NCH         = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       ch_req,
    input  logic [NCH-1:0]       ch_we,
    input  logic [NCH*NBITS-1:0] ch_addr,
    input  logic [NCH*NBITS-1:0] ch_wdata,
    output logic [NCH-1:0]       ch_valid,
    output logic [NCH-1:0]       ch_err,
    output logic [NBITS-1:0]     ch_rdata,
    output logic [NCH-1:0]       ch_stall,
    output logic                 busy,
    output logic                 mem_req,
    input  logic                 mem_rdy,
    output logic                 mem_we,
    output logic [NBITS-1:0]     mem_addr,
    output logic [NBITS-1:0]     mem_wdata,
    input  logic                 mem_valid,
    input  logic [NBITS-1:0]     mem_rdata
);

    localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1;
    // A zero timeout still needs a 1-bit counter so the declarations stay legal.
    localparam int CW  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    // Abort fires on the WAIT cycle in which the counter would reach TIMEOUT_CYC.
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   id_q, id_d;
    logic             we_q, we_d;
    logic [NBITS-1:0] addr_q, addr_d;
    logic [NBITS-1:0] wdata_q, wdata_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mem_req_q, mem_req_d;
    logic [NCH-1:0]   ch_valid_q, ch_valid_d;
    logic [NCH-1:0]   ch_err_q, ch_err_d;
    logic [NBITS-1:0] rdata_q, rdata_d;
`ifdef ARB_RR_EN
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
`endif

    logic [IDW-1:0]   win_id;
    logic             win_any;

`ifdef ARB_RR_EN
    // Round-robin pick: first requester at or after the pointer, wrapping past NCH-1.
    always_comb begin
        int idx;
        idx     = 0;
        win_id  = '0;
        win_any = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (!win_any && ch_req[idx]) begin
                win_any = 1'b1;
                win_id  = IDW'(idx);
            end
        end
    end
`else
    // Fixed-priority pick: scanning downward leaves the lowest requesting index.
    always_comb begin
        win_id  = '0;
        win_any = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (ch_req[k]) begin
                win_any = 1'b1;
                win_id  = IDW'(k);
            end
        end
    end
`endif

    // Next-state and registered-output computation for the IDLE/REQ/WAIT handshake.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        mem_req_d  = mem_req_q;
        ch_valid_d = '0;
        ch_err_d   = '0;
        rdata_d    = rdata_q;
`ifdef ARB_RR_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_any) begin
                    id_d      = win_id;
                    we_d      = ch_we[win_id];
                    addr_d    = ch_addr[win_id*NBITS +: NBITS];
                    wdata_d   = ch_wdata[win_id*NBITS +: NBITS];
                    mem_req_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_REQ;
`ifdef ARB_RR_EN
                    if (win_id == IDW'(NCH - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = win_id + 1'b1;
                    end
`endif
                end
            end
            S_REQ: begin
                // No timeout here: a memory that never accepts stalls the channel indefinitely.
                if (mem_req_q && mem_rdy) begin
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_valid) begin
                    // A response arriving on the timeout cycle still counts as success.
                    ch_valid_d[id_q] = 1'b1;
                    rdata_d          = we_q ? '0 : mem_rdata;
                    cnt_d            = '0;
                    state_d          = S_IDLE;
                end else if ((TIMEOUT_CYC != 0) && (cnt_q == TO_LAST)) begin
                    ch_valid_d[id_q] = 1'b1;
                    ch_err_d[id_q]   = 1'b1;
                    rdata_d          = '0;
                    cnt_d            = '0;
                    state_d          = S_IDLE;
                end else if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                cnt_d     = '0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction without a completion pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            id_q       <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            ch_valid_q <= '0;
            ch_err_q   <= '0;
            rdata_q    <= '0;
`ifdef ARB_RR_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            mem_req_q  <= mem_req_d;
            ch_valid_q <= ch_valid_d;
            ch_err_q   <= ch_err_d;
            rdata_q    <= rdata_d;
`ifdef ARB_RR_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    assign ch_valid  = ch_valid_q;
    assign ch_err    = ch_err_q;
    assign ch_rdata  = rdata_q;
    // Stall releases in the completion cycle so the pipeline can advance on the pulse.
    assign ch_stall  = ch_req & ~ch_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign mem_req   = mem_req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter (NCH=2, TIMEOUT_CYC=4)
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  ch_req;
    logic [1:0]  ch_we;
    logic [63:0] ch_addr;
    logic [63:0] ch_wdata;
    logic [1:0]  ch_valid;
    logic [1:0]  ch_err;
    logic [31:0] ch_rdata;
    logic [1:0]  ch_stall;
    logic        busy;
    logic        mem_req;
    logic        mem_rdy;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_valid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.NBITS(32), .NCH(2), .TIMEOUT_CYC(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ch_req    (ch_req),
        .ch_we     (ch_we),
        .ch_addr   (ch_addr),
        .ch_wdata  (ch_wdata),
        .ch_valid  (ch_valid),
        .ch_err    (ch_err),
        .ch_rdata  (ch_rdata),
        .ch_stall  (ch_stall),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_rdy   (mem_rdy),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_valid (mem_valid),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ch_req    = '0;
        ch_we     = '0;
        mem_rdy   = 1'b0;
        mem_valid = 1'b0;
        mem_rdata = '0;
        rst       = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    // Accept the pending request with rdy high and answer one cycle later.
    task automatic serve(input logic [31:0] rd_in, output logic [31:0] addr, output logic we,
                         output logic [31:0] wd, output logic [1:0] vld, output logic [31:0] rd,
                         output bit ok);
        ok = 1'b0; addr = '0; we = 1'b0; wd = '0; vld = '0; rd = '0;
        mem_rdy = 1'b1;
        for (int i = 0; i < 20 && !mem_req; i++) step();
        if (!mem_req) return;
        addr = mem_addr; we = mem_we; wd = mem_wdata;
        step();
        mem_valid = 1'b1; mem_rdata = rd_in;
        step();
        mem_valid = 1'b0;
        vld = ch_valid; rd = ch_rdata; ok = 1'b1;
    endtask

    task automatic test_reset();
        ch_req = '0; ch_we = '0; ch_addr = '0; ch_wdata = '0;
        mem_rdy = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
        rst = 1'b0;
        step();
        checks++;
        if ({mem_req, busy, ch_valid, ch_err, mem_we} !== 7'b0 || ch_rdata !== 32'h0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b busy=%b vld=%b err=%b rdata=%h addr=%h, required all zero",
                     mem_req, busy, ch_valid, ch_err, ch_rdata, mem_addr);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        ch_addr[31:0] = 32'h100; ch_we = 2'b00; mem_rdy = 1'b1; ch_req = 2'b01;
        #1;
        checks++;
        if (ch_stall !== 2'b01) begin errors++; $display("FAIL t1_stall_N: got %b need 01", ch_stall); end
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t1_req: req=%b addr=%h we=%b busy=%b need 1/100/0/1", mem_req, mem_addr, mem_we, busy);
        end
        step();
        checks++;
        if (mem_req !== 1'b0 || ch_valid !== 2'b00 || ch_stall !== 2'b01) begin
            errors++;
            $display("FAIL t1_wait: req=%b vld=%b stall=%b need 0/00/01", mem_req, ch_valid, ch_stall);
        end
        mem_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
        step();
        checks++;
        if (ch_valid !== 2'b01 || ch_err !== 2'b00 || ch_rdata !== 32'hDEADBEEF || ch_stall !== 2'b00) begin
            errors++;
            $display("FAIL t1_done: vld=%b err=%b rdata=%h stall=%b need 01/00/deadbeef/00",
                     ch_valid, ch_err, ch_rdata, ch_stall);
        end
        ch_req = 2'b00; mem_valid = 1'b0;
        step();
        checks++;
        if (ch_valid !== 2'b00 || busy !== 1'b0 || ch_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL t1_after: vld=%b busy=%b rdata=%h need 00/0/deadbeef", ch_valid, busy, ch_rdata);
        end
    endtask

    task automatic test_priority();
        logic [31:0] a, wd, rd; logic we; logic [1:0] v; bit ok;
        do_reset();
        ch_addr = {32'h200, 32'h104}; ch_wdata = {32'h55, 32'h0}; ch_we = 2'b10; ch_req = 2'b11;
        serve(32'h11112222, a, we, wd, v, rd, ok);
        ch_req[0] = 1'b0;
        checks++;
        if (!ok || a !== 32'h104 || we !== 1'b0 || v !== 2'b01 || rd !== 32'h11112222) begin
            errors++;
            $display("FAIL t2_first: ok=%0d addr=%h we=%b vld=%b rdata=%h need 1/104/0/01/11112222", ok, a, we, v, rd);
        end
        serve(32'hCAFEF00D, a, we, wd, v, rd, ok);
        ch_req[1] = 1'b0;
        checks++;
        if (!ok || a !== 32'h200 || we !== 1'b1 || wd !== 32'h55 || v !== 2'b10 || rd !== 32'h0) begin
            errors++;
            $display("FAIL t2_second: ok=%0d addr=%h we=%b wd=%h vld=%b rdata=%h need 1/200/1/55/10/0",
                     ok, a, we, wd, v, rd);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, wd, rd; logic we; logic [1:0] v; bit ok;
        logic [1:0] exp_v [4];
`ifdef ARB_RR_EN
        exp_v = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_v = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        do_reset();
        ch_addr = {32'h208, 32'h108}; ch_we = 2'b00; ch_req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            serve(32'h1000 + t, a, we, wd, v, rd, ok);
            checks++;
            if (!ok || v !== exp_v[t] || a !== (exp_v[t][1] ? 32'h208 : 32'h108)) begin
                errors++;
                $display("FAIL t2_hold_%0d: ok=%0d vld=%b addr=%h need vld=%b", t, ok, v, a, exp_v[t]);
            end
        end
        ch_req = 2'b00;
        step();
    endtask

    task automatic test_rdy_hold();
        int bad;
        ch_addr[31:0] = 32'h300; ch_we = 2'b00; mem_rdy = 1'b0; ch_req = 2'b01;
        step();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req !== 1'b1 || mem_addr !== 32'h300 || ch_err !== 2'b00 || ch_valid !== 2'b00) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL t3_hold: %0d bad cycles, need 0", bad); end
        mem_rdy = 1'b1;
        step();
        mem_valid = 1'b1; mem_rdata = 32'h12345678;
        step();
        mem_valid = 1'b0; ch_req = 2'b00;
        checks++;
        if (ch_valid !== 2'b01 || ch_err !== 2'b00 || ch_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL t3_done: vld=%b err=%b rdata=%h need 01/00/12345678", ch_valid, ch_err, ch_rdata);
        end
        step();
    endtask

    task automatic test_timeout();
        ch_addr[63:32] = 32'h400; ch_we = 2'b00; mem_rdy = 1'b1; ch_req = 2'b10;
        step();
        step();
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (ch_valid !== 2'b00 || busy !== 1'b1) begin
            errors++; $display("FAIL t4_early: vld=%b busy=%b need 00/1", ch_valid, busy);
        end
        step();
        ch_req = 2'b00;
        checks++;
        if (ch_valid !== 2'b10 || ch_err !== 2'b10 || ch_rdata !== 32'h0) begin
            errors++;
            $display("FAIL t4_abort: vld=%b err=%b rdata=%h need 10/10/0", ch_valid, ch_err, ch_rdata);
        end
        step();
        checks++;
        if (busy !== 1'b0 || ch_valid !== 2'b00 || ch_err !== 2'b00) begin
            errors++; $display("FAIL t4_idle: busy=%b vld=%b err=%b need 0/00/00", busy, ch_valid, ch_err);
        end
        ch_addr[31:0] = 32'h404; ch_req = 2'b01;
        step();
        step();
        for (int i = 0; i < 3; i++) step();
        mem_valid = 1'b1; mem_rdata = 32'hA5A5A5A5;
        step();
        mem_valid = 1'b0; ch_req = 2'b00;
        checks++;
        if (ch_valid !== 2'b01 || ch_err !== 2'b00 || ch_rdata !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL t4_race: vld=%b err=%b rdata=%h need 01/00/a5a5a5a5", ch_valid, ch_err, ch_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, wd, rd; logic we; logic [1:0] v; bit ok;
        ch_addr[31:0] = 32'h480; ch_we = 2'b00; mem_rdy = 1'b1; ch_req = 2'b01;
        step();
        step();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL t5_inwait: busy=%b need 1", busy); end
        rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || ch_valid !== 2'b00 || busy !== 1'b0 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL t5_abort: req=%b vld=%b busy=%b addr=%h need 0/00/0/0", mem_req, ch_valid, busy, mem_addr);
        end
        mem_valid = 1'b1; ch_req = 2'b00;
        step();
        mem_valid = 1'b0; rst = 1'b1;
        step();
        checks++;
        if (ch_valid !== 2'b00 || busy !== 1'b0) begin
            errors++; $display("FAIL t5_post: vld=%b busy=%b need 00/0", ch_valid, busy);
        end
        ch_addr[63:32] = 32'h500; ch_req = 2'b10;
        serve(32'h0BADF00D, a, we, wd, v, rd, ok);
        ch_req = 2'b00;
        checks++;
        if (!ok || a !== 32'h500 || v !== 2'b10 || rd !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL t5_fresh: ok=%0d addr=%h vld=%b rdata=%h need 1/500/10/0badf00d", ok, a, v, rd);
        end
        step();
    endtask

    task automatic test_idle_valid();
        int bad;
        bad = 0;
        ch_req = 2'b00; mem_valid = 1'b1; mem_rdata = 32'hFFFF0000;
        for (int i = 0; i < 3; i++) begin
            step();
            if (ch_valid !== 2'b00 || busy !== 1'b0 || ch_rdata !== 32'h0BADF00D) bad++;
        end
        mem_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL t6_idle_valid: %0d bad cycles (vld=%b busy=%b rdata=%h), need 0", bad, ch_valid, busy, ch_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority();
        test_back_to_back();
        test_rdy_hold();
        test_timeout();
        test_reset_mid();
        test_idle_valid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
